// File: rtl/flash_frame_loader.sv
// Fills a 4-word FFT sample store from a valid/ready stream and holds the frame until acknowledged.
// Optional macro BIT_REVERSE_EN selects bit-reversed write addressing (0,2,1,3).
module flash_frame_loader #(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [N-1:0]     i_word,
    output logic             o_ready,
    input  logic             i_flush,
    input  logic             i_frame_ack,
    output logic             o_wr_en,
    output logic [1:0]       o_wr_addr,
    output logic [N-1:0]     o_wr_word,
    output logic             o_frame_valid,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [2:0]       o_fill_level
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        COMMIT = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_wptr;
    logic             r_wr_en;
    logic [1:0]       r_wr_addr;
    logic [N-1:0]     r_wr_word;
    logic             r_frame_valid;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [2:0]       r_fill_level;
    logic [1:0]       w_map_addr;

`ifdef BIT_REVERSE_EN
    assign w_map_addr = {r_wptr[0], r_wptr[1]};
`else
    assign w_map_addr = r_wptr;
`endif

    assign o_ready = (r_state == FILL) && !i_flush;

    // Address/data registers only move on an accepted sample: the store latches them continuously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= FILL;
            r_wptr        <= 2'd0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= 2'd0;
            r_wr_word     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= '0;
            r_fill_level  <= 3'd0;
        end else begin
            r_wr_en <= 1'b0;
            if (i_flush) begin
                r_state       <= FILL;
                r_wptr        <= 2'd0;
                r_fill_level  <= 3'd0;
                r_frame_valid <= 1'b0;
            end else begin
                case (r_state)
                    FILL: begin
                        if (i_valid) begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= w_map_addr;
                            r_wr_word    <= i_word;
                            r_wptr       <= r_wptr + 2'd1;
                            r_fill_level <= r_fill_level + 3'd1;
                            if (r_wptr == 2'd3) begin
                                r_state <= COMMIT;
                            end
                        end
                    end
                    COMMIT: begin
                        r_frame_valid <= 1'b1;
                        r_state       <= FULL;
                    end
                    FULL: begin
                        if (i_frame_ack) begin
                            r_frame_valid <= 1'b0;
                            r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
                            r_fill_level  <= 3'd0;
                            r_state       <= FILL;
                        end
                    end
                    default: begin
                        r_state <= FILL;
                    end
                endcase
            end
        end
    end

    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_word     = r_wr_word;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_fill_level  = r_fill_level;

endmodule
